// File: rtl/trig_phase_frame_decoder.sv
// trig_phase_frame_decoder
//   Receives the clk160 trigger-phase byte stream (one 32-bit frame per clk40
//   period, byte0 first). It finds 4-byte frame alignment on the idle word and
//   holds it. Each aligned frame is decoded into a trigger event carrying the
//   recovered (bit-reversed) phase and a frame timestamp. Trigger, error and
//   lock-loss counters are kept for the register block.
//
// Ports
//   clk160           in   byte clock, rising edge
//   resetn           in   synchronous active-low reset
//   din[7:0]         in   received byte, one per cycle
//   clear_counters   in   pulse, clears trig/err/lock-loss counters
//   locked           out  frame alignment held (state == LOCKED)
//   trig_valid       out  one-cycle pulse per decoded trigger frame
//   trig_phase[7:0]  out  recovered phase, held between triggers
//   trig_timestamp   out  frame index of the trigger since lock
//   trig_count[31:0] out  decoded triggers, wraps
//   err_count[15:0]  out  bad frames while locked, saturating
//   lock_loss_count  out  LOCKED->HUNT transitions, saturating
//
// state  | meaning
// HUNT   | sliding search for IDLE_WORD on every byte
// VERIFY | aligned, counting consecutive idle frames toward LOCK_COUNT
// LOCKED | aligned, decoding frames at every boundary
module trig_phase_frame_decoder #(
  parameter logic [31:0] IDLE_WORD    = 32'h33333335,
  parameter int unsigned LOCK_COUNT   = 4,
  parameter int unsigned UNLOCK_COUNT = 3,
  parameter int unsigned TS_WIDTH     = 32
) (
  input  logic                clk160,
  input  logic                resetn,
  input  logic [7:0]          din,
  input  logic                clear_counters,
  output logic                locked,
  output logic                trig_valid,
  output logic [7:0]          trig_phase,
  output logic [TS_WIDTH-1:0] trig_timestamp,
  output logic [31:0]         trig_count,
  output logic [15:0]         err_count,
  output logic [7:0]          lock_loss_count
);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] LP_LOCK   = LOCK_COUNT[3:0];
  localparam logic [3:0] LP_UNLOCK = UNLOCK_COUNT[3:0];

  state_t              r_state;
  state_t              w_state_nxt;
  logic [23:0]         r_sr;
  logic [1:0]          r_slot;
  logic [3:0]          r_good_cnt;
  logic [3:0]          r_bad_cnt;
  logic [TS_WIDTH-1:0] r_frame_ts;

  logic [31:0] w_window;
  logic        w_boundary;
  logic        w_is_idle;
  logic        w_is_trig;
  logic [3:0]  w_good_inc;
  logic [3:0]  w_bad_inc;
  logic [7:0]  w_phase;
  logic        w_hunt_hit;
  logic        w_verify_good;
  logic        w_lock_idle;
  logic        w_lock_trig;
  logic        w_lock_bad;
  logic        w_unlock;
  logic        w_enter_lock;

  // din is byte3 of the candidate frame, r_sr[7:0] the oldest byte0.
  assign w_window   = {din, r_sr};
  assign w_boundary = (r_slot == 2'd3);
  assign w_is_idle  = (w_window == IDLE_WORD);
  assign w_is_trig  = (w_window[23:0] == 24'd0);
  assign w_good_inc = r_good_cnt + 4'd1;
  assign w_bad_inc  = r_bad_cnt + 4'd1;

  // The serializer sends the phase MSB-first, so byte3 arrives bit-reversed.
  always_comb begin
    w_phase = 8'd0;
    for (int i = 0; i < 8; i++) begin
      w_phase[i] = w_window[31-i];
    end
  end

  always_ff @(posedge clk160) begin
    if (!resetn) begin
      r_state <= ST_HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_hunt_hit    = 1'b0;
    w_verify_good = 1'b0;
    w_lock_idle   = 1'b0;
    w_lock_trig   = 1'b0;
    w_lock_bad    = 1'b0;
    w_unlock      = 1'b0;
    case (r_state)
      ST_HUNT: begin
        if (w_is_idle) begin
          w_hunt_hit  = 1'b1;
          w_state_nxt = (LP_LOCK == 4'd1) ? ST_LOCKED : ST_VERIFY;
        end
      end
      ST_VERIFY: begin
        if (w_boundary) begin
          if (w_is_idle) begin
            w_verify_good = 1'b1;
            if (w_good_inc == LP_LOCK) begin
              w_state_nxt = ST_LOCKED;
            end
          end else if (!w_is_trig) begin
            w_state_nxt = ST_HUNT;
          end
        end
      end
      ST_LOCKED: begin
        if (w_boundary) begin
          if (w_is_idle) begin
            w_lock_idle = 1'b1;
          end else if (w_is_trig) begin
            w_lock_trig = 1'b1;
          end else begin
            w_lock_bad = 1'b1;
            if (w_bad_inc == LP_UNLOCK) begin
              w_unlock    = 1'b1;
              w_state_nxt = ST_HUNT;
            end
          end
        end
      end
      default: w_state_nxt = ST_HUNT;
    endcase
  end

  assign w_enter_lock = (w_state_nxt == ST_LOCKED) && (r_state != ST_LOCKED);

  always_ff @(posedge clk160) begin
    if (!resetn) begin
      r_sr            <= 24'd0;
      r_slot          <= 2'd0;
      r_good_cnt      <= 4'd0;
      r_bad_cnt       <= 4'd0;
      r_frame_ts      <= '0;
      locked          <= 1'b0;
      trig_valid      <= 1'b0;
      trig_phase      <= 8'd0;
      trig_timestamp  <= '0;
      trig_count      <= 32'd0;
      err_count       <= 16'd0;
      lock_loss_count <= 8'd0;
    end else begin
      r_sr   <= {din, r_sr[23:8]};
      // A hunt hit means din is byte3 now, so the next byte is byte0.
      r_slot <= w_hunt_hit ? 2'd0 : r_slot + 2'd1;

      if (w_hunt_hit) begin
        r_good_cnt <= 4'd1;
      end else if (w_verify_good) begin
        r_good_cnt <= w_good_inc;
      end

      if (w_enter_lock || w_lock_idle || w_lock_trig || w_unlock) begin
        r_bad_cnt <= 4'd0;
      end else if (w_lock_bad) begin
        r_bad_cnt <= w_bad_inc;
      end

      // Event capture uses the old value, so the first locked frame is ts 0.
      if (w_enter_lock) begin
        r_frame_ts <= '0;
      end else if ((r_state == ST_LOCKED) && w_boundary) begin
        r_frame_ts <= r_frame_ts + TS_WIDTH'(1);
      end

      locked     <= (w_state_nxt == ST_LOCKED);
      trig_valid <= w_lock_trig;
      if (w_lock_trig) begin
        trig_phase     <= w_phase;
        trig_timestamp <= r_frame_ts;
      end

      // Clear has priority over any coincident increment.
      if (clear_counters) begin
        trig_count      <= 32'd0;
        err_count       <= 16'd0;
        lock_loss_count <= 8'd0;
      end else begin
        if (w_lock_trig) begin
          trig_count <= trig_count + 32'd1;
        end
        if (w_lock_bad && (err_count != 16'hFFFF)) begin
          err_count <= err_count + 16'd1;
        end
        if (w_unlock && (lock_loss_count != 8'hFF)) begin
          lock_loss_count <= lock_loss_count + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_trig_phase_frame_decoder.sv
module tb_trig_phase_frame_decoder;

  logic        clk160 = 1'b0;
  logic        resetn;
  logic [7:0]  din;
  logic        clear_counters;
  logic        locked;
  logic        trig_valid;
  logic [7:0]  trig_phase;
  logic [31:0] trig_timestamp;
  logic [31:0] trig_count;
  logic [15:0] err_count;
  logic [7:0]  lock_loss_count;

  always #5 clk160 = ~clk160;

  trig_phase_frame_decoder dut (
    .clk160          (clk160),
    .resetn          (resetn),
    .din             (din),
    .clear_counters  (clear_counters),
    .locked          (locked),
    .trig_valid      (trig_valid),
    .trig_phase      (trig_phase),
    .trig_timestamp  (trig_timestamp),
    .trig_count      (trig_count),
    .err_count       (err_count),
    .lock_loss_count (lock_loss_count)
  );

  typedef struct {
    logic [7:0]  phase;
    logic [31:0] ts;
    logic [31:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  bit          tb_locked = 0;
  logic [31:0] tb_ts = 0;
  logic [31:0] tb_cnt = 0;
  logic        prev_tv = 1'b0;

  localparam logic [31:0] IDLE = 32'h33333335;
  localparam logic [31:0] BAD  = 32'h00001200;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = b[i];
    return r;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit clr);
    din = b;
    clear_counters = clr;
    @(posedge clk160);
    #1;
    clear_counters = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] w);
    send_byte(w[7:0], 0);
    send_byte(w[15:8], 0);
    send_byte(w[23:16], 0);
    send_byte(w[31:24], 0);
    if (tb_locked) tb_ts++;
  endtask

  task automatic send_trig(input logic [7:0] b3, input bit clr);
    exp_t e;
    if (tb_locked) begin
      tb_cnt  = clr ? 32'd0 : tb_cnt + 32'd1;
      e.phase = rev8(b3);
      e.ts    = tb_ts;
      e.cnt   = tb_cnt;
      exp_q.push_back(e);
    end
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(b3, clr);
    if (tb_locked) tb_ts++;
  endtask

  always @(negedge clk160) begin
    exp_t e;
    if (trig_valid) begin
      chk("trig_spacing", {63'd0, prev_tv}, 64'd0);
      if (exp_q.size() == 0) begin
        chk("trig_unexpected", exp_q.size(), 64'd1);
      end else begin
        e = exp_q.pop_front();
        chk("trig_phase", trig_phase, e.phase);
        chk("trig_timestamp", trig_timestamp, e.ts);
        chk("trig_count_at_trig", trig_count, e.cnt);
      end
    end
    prev_tv = trig_valid;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0;
    din = 8'h00;
    clear_counters = 1'b0;
    @(posedge clk160);
    #1;
    send_byte(8'h35, 0);
    send_byte(8'h33, 0);
    chk("rst_locked", locked, 0);
    chk("rst_trig_valid", trig_valid, 0);
    chk("rst_trig_phase", trig_phase, 0);
    chk("rst_trig_ts", trig_timestamp, 0);
    chk("rst_trig_count", trig_count, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_lock_loss", lock_loss_count, 0);

    // Initial lock, stream starting at byte offset 2.
    resetn = 1'b1;
    send_byte(8'h33, 0);
    send_byte(8'h33, 0);
    send_frame(IDLE);
    send_frame(IDLE);
    send_frame(IDLE);
    chk("lock_after_3", locked, 0);
    send_frame(IDLE);
    chk("lock_after_4", locked, 1);
    chk("lock_err_count", err_count, 0);
    tb_locked = 1;
    tb_ts = 0;

    // Trigger after two idle frames: timestamp 2.
    send_frame(IDLE);
    send_frame(IDLE);
    send_trig(8'h58, 0);
    send_frame(IDLE);
    chk("trig_count_1", trig_count, 1);
    chk("trig_valid_low", trig_valid, 0);

    // Single bad frame keeps lock.
    send_frame(BAD);
    send_frame(IDLE);
    chk("err_count_1", err_count, 1);
    chk("locked_after_bad", locked, 1);

    // Three consecutive bad frames drop lock.
    send_frame(BAD);
    send_frame(BAD);
    chk("locked_after_2bad", locked, 1);
    send_frame(BAD);
    tb_locked = 0;
    chk("locked_after_3bad", locked, 0);
    chk("lock_loss_1", lock_loss_count, 1);
    chk("err_count_4", err_count, 4);

    // Relock; timestamp restarts at 0.
    send_frame(IDLE);
    send_frame(IDLE);
    send_frame(IDLE);
    chk("relock_after_3", locked, 0);
    send_frame(IDLE);
    chk("relock_after_4", locked, 1);
    tb_locked = 1;
    tb_ts = 0;
    send_trig(8'h58, 0);

    // Count up to 5, then clear coinciding with the increment.
    send_trig(8'hC3, 0);
    send_trig(8'h01, 0);
    send_trig(8'hFF, 0);
    chk("trig_count_5", trig_count, 5);
    send_trig(8'h40, 1);
    chk("clr_trig_count", trig_count, 0);
    chk("clr_err_count", err_count, 0);
    chk("clr_lock_loss", lock_loss_count, 0);
    chk("clr_keeps_lock", locked, 1);
    send_trig(8'h58, 0);
    chk("trig_count_after_clr", trig_count, 1);
    send_frame(BAD);
    chk("err_before_rst", err_count, 1);

    // Reset mid-frame while locked.
    send_byte(8'h35, 0);
    send_byte(8'h33, 0);
    resetn = 1'b0;
    send_byte(8'h33, 0);
    chk("rst2_locked", locked, 0);
    chk("rst2_trig_valid", trig_valid, 0);
    chk("rst2_trig_phase", trig_phase, 0);
    chk("rst2_trig_ts", trig_timestamp, 0);
    chk("rst2_trig_count", trig_count, 0);
    chk("rst2_err_count", err_count, 0);
    chk("rst2_lock_loss", lock_loss_count, 0);
    resetn = 1'b1;
    tb_locked = 0;
    tb_cnt = 0;

    // Trigger during VERIFY is ignored and does not break verification.
    send_frame(IDLE);
    send_frame(IDLE);
    send_trig(8'h80, 0);
    chk("verify_trig_count", trig_count, 0);
    chk("verify_locked", locked, 0);
    send_frame(IDLE);
    chk("verify_lock_3", locked, 0);
    send_frame(IDLE);
    chk("verify_lock_4", locked, 1);
    chk("verify_err_count", err_count, 0);
    tb_locked = 1;
    tb_ts = 0;
    send_frame(IDLE);
    send_trig(8'h58, 0);
    send_frame(IDLE);
    send_frame(IDLE);
    chk("final_trig_count", trig_count, 1);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/trig_phase_frame_decoder.md
Name: trig_phase_frame_decoder

Overview:
- Receives the 8-bit-per-clk160 trigger-phase byte stream produced by the external trigger logic. The stream carries one 32-bit frame per clk40 period: an idle word or a trigger word carrying a bit-reversed phase.
- Finds and holds 4-byte frame alignment, then decodes each frame into a trigger event with recovered phase and frame timestamp.
- Maintains trigger, error and lock-loss counters for the IPIF register block.
- Sits on the receiving side of the link (loopback or downstream board), directly downstream of the phase serializer.

Parameters:
- IDLE_WORD, 32'h33333335, idle frame value; byte0 = bits[7:0] is sent first.
- LOCK_COUNT, 4, consecutive idle frames required to declare lock (including the frame found in HUNT); range 1..15.
- UNLOCK_COUNT, 3, consecutive bad frames in LOCKED that force re-hunt; range 1..15.
- TS_WIDTH, 32, width of the frame timestamp.

Ports:
- clk160  in  1  byte clock; all logic is on the rising edge.
- resetn  in  1  reset; synchronous, active-low.
- din  in  8  received byte, one per cycle.
- clear_counters  in  1  single-cycle pulse; clears trig_count, err_count and lock_loss_count.
- locked  out  1  frame alignment held.
- trig_valid  out  1  one-cycle pulse per decoded trigger frame.
- trig_phase  out  8  recovered phase; valid when trig_valid=1, held otherwise.
- trig_timestamp  out  TS_WIDTH  frame index of the trigger since lock was acquired.
- trig_count  out  32  decoded triggers; wraps.
- err_count  out  16  bad frames while LOCKED; saturates at 16'hFFFF.
- lock_loss_count  out  8  LOCKED->HUNT transitions; saturates at 8'hFF.

Behaviour:
- Byte history: the shift register sr[23:0] <= {din, sr[23:8]} every cycle.
- Window: window = {din, sr[23:0]}. din is byte3, sr[7:0] is byte0 (oldest).
- Slot counter slot[1:0] increments every cycle and wraps 3->0. A frame boundary is any cycle with slot==3.
- Frame classification at a boundary:
  - IDLE if window==IDLE_WORD.
  - TRIG if window[23:0]==0.
  - BAD otherwise.
- Phase recovery: trig_phase[i] = window[31-i] for i=0..7, i.e. byte3 bit-reversed.
- State machine: states HUNT, VERIFY, LOCKED; reset state is HUNT.
- HUNT:
  - Evaluates window every cycle, ignoring slot.
  - On window==IDLE_WORD: slot<=0, good_cnt<=1; go to LOCKED if LOCK_COUNT==1, otherwise go to VERIFY.
- VERIFY (evaluated at boundaries only):
  - IDLE: good_cnt+1; on reaching LOCK_COUNT go to LOCKED.
  - TRIG: ignored; no event and no count change.
  - BAD: go to HUNT; err_count is not touched.
- LOCKED (evaluated at boundaries only):
  - IDLE: clears bad_cnt.
  - TRIG: clears bad_cnt; registers trig_valid=1, trig_phase and trig_timestamp=frame_ts; trig_count+1.
  - BAD: err_count+1 (saturating) and bad_cnt+1. When bad_cnt reaches UNLOCK_COUNT: go to HUNT, lock_loss_count+1 (saturating), locked<=0 in the same edge.
- Frame timestamp frame_ts:
  - Loaded with 0 on the edge entering LOCKED.
  - Increments at every LOCKED boundary after the event is captured; wraps modulo 2^TS_WIDTH.
  - The first frame after lock therefore has timestamp 0.
- locked = 1 exactly while state==LOCKED; registered, so it rises on the edge that enters LOCKED.
- Latency: trig_valid rises on the edge after the cycle in which byte3 of the trigger frame is on din (1 cycle).
- clear_counters:
  - Clears all three counters on the next edge.
  - If it coincides with an increment, the clear wins and the result is 0.
  - Does not affect alignment state or frame_ts.
- Reset (resetn=0 at an edge):
  - locked, trig_valid, trig_phase, trig_timestamp, trig_count, err_count, lock_loss_count all become 0.
  - sr, slot, good_cnt, bad_cnt and frame_ts become 0; state becomes HUNT.
  - Reset mid-frame discards the partial frame; alignment restarts from HUNT.
- At most one event per boundary. trig_valid never asserts in consecutive cycles; minimum spacing is 4 cycles.

Test Plan:
- Reset, then continuous idle bytes 35,33,33,33 starting at byte offset 2 after reset release -> locked=1 one cycle after byte3 of the 4th complete idle frame; err_count=0.
- Locked, then frame 00,00,00,58 -> trig_valid high for exactly 1 cycle, one cycle after byte 58; trig_phase=8'h1A; trig_count=1; trig_timestamp equals the number of idle frames since lock.
- Locked, one frame 00,12,00,00 then idle -> err_count=1, locked stays 1. Then 3 consecutive bad frames -> locked=0 after the 3rd, lock_loss_count=1, re-lock after 4 idle frames with frame_ts restarted at 0.
- In VERIFY (2 idle frames seen), send trigger frame 00,00,00,80 -> no trig_valid, trig_count unchanged, lock still achieved after 2 more idle frames.
- clear_counters pulsed in the same cycle trig_valid's increment occurs (trig_count=5 before) -> trig_count=0 afterwards; the next trigger gives 1.
- resetn=0 for 1 cycle while locked with counters non-zero -> all outputs 0 on the following cycle; state re-enters HUNT and re-locks normally.
